// File: rtl/predict_pc_pkg.sv
// Shared Y86 instruction codes, bus widths and the prediction-source selector
// used by predict_pc and its return-address stack.
`default_nettype none

`ifndef PREDICT_PC_DEFINES
`define PREDICT_PC_DEFINES
`define WORD 31:0
`define BYTE 7:0
`define RAS_DEPTH_DEF 8
`endif

package predict_pc_pkg;

   localparam logic [`BYTE] INOP    = 8'h01;
   localparam logic [`BYTE] IRRMOVL = 8'h02;
   localparam logic [`BYTE] IJXX    = 8'h07;
   localparam logic [`BYTE] ICALL   = 8'h08;
   localparam logic [`BYTE] IRET    = 8'h09;

   typedef enum logic [1:0] {
      SRC_VALP = 2'd0,
      SRC_VALC = 2'd1,
      SRC_RAS  = 2'd2
   } pred_src_e;

   // Jumps and calls always predict taken; a return only trusts a non-empty stack.
   function automatic pred_src_e pred_source(input logic [`BYTE] icode,
                                             input logic         ras_hit);
      if (icode == IJXX || icode == ICALL) begin
         return SRC_VALC;
      end
      if (icode == IRET && ras_hit) begin
         return SRC_RAS;
      end
      return SRC_VALP;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// pops on empty are ignored, flush empties it. Only compiled when RAS_EN is set.
`default_nettype none

`ifdef RAS_EN
module ras_stack #(
   parameter int DEPTH = `RAS_DEPTH_DEF
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [`WORD] data_i,
   output logic [`WORD] top_o,
   output logic [4:0]   count_o
);

   localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] C_FULL = 5'(DEPTH);

   logic [`WORD]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [4:0]    r_count;
   logic          w_do_write;

   assign w_do_write = push && !flush && rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp    <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wp    <= '0;
         r_count <= '0;
      end else if (push) begin
         r_wp <= r_wp + 1'b1;
         if (r_count != C_FULL) begin
            r_count <= r_count + 5'd1;
         end
      end else if (pop && r_count != 5'd0) begin
         r_wp    <= r_wp - 1'b1;
         r_count <= r_count - 5'd1;
      end
   end

   // Storage is left uninitialised; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_do_write) begin
         r_mem[r_wp] <= data_i;
      end
   end

   assign top_o   = r_mem[r_wp - 1'b1];
   assign count_o = r_count;

endmodule
`endif

`default_nettype wire

// File: rtl/predict_pc.sv
// Fetch-stage PC predictor with optional return-address stack (macro RAS_EN).
// Without RAS_EN returns fall through to valP and the stack outputs read zero.
`default_nettype none

module predict_pc
   import predict_pc_pkg::*;
#(
   parameter int RAS_DEPTH = `RAS_DEPTH_DEF
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [`BYTE] f_icode_i,
   input  logic [`WORD] f_valC_i,
   input  logic [`WORD] f_valP_i,
   input  logic         F_stall_i,
   input  logic [`BYTE] M_icode_i,
   input  logic         M_Cnd_i,
   output logic [`WORD] F_predPC_o,
   output logic [4:0]   ras_count_o,
   output logic         ras_flush_o
);

   logic         w_mispredict;
   logic         w_ras_hit;
   logic [`WORD] w_ras_top;
   logic [`WORD] w_next_pc;
   pred_src_e    w_src;
   logic [`WORD] r_pred_pc;

   assign w_mispredict = (M_icode_i == IJXX) && !M_Cnd_i;

`ifdef RAS_EN
   logic w_push;
   logic w_pop;
   logic r_flush;

   assign w_push = !F_stall_i && (f_icode_i == ICALL);
   assign w_pop  = !F_stall_i && (f_icode_i == IRET);

   ras_stack #(
      .DEPTH   (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .push    (w_push),
      .pop     (w_pop),
      .flush   (w_mispredict),
      .data_i  (f_valP_i),
      .top_o   (w_ras_top),
      .count_o (ras_count_o)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flush <= 1'b0;
      end else begin
         r_flush <= w_mispredict;
      end
   end

   assign w_ras_hit   = (ras_count_o != 5'd0);
   assign ras_flush_o = r_flush;
`else
   logic w_unused_mispredict;

   assign w_unused_mispredict = w_mispredict;
   assign w_ras_hit           = 1'b0;
   assign w_ras_top           = '0;
   assign ras_count_o         = 5'd0;
   assign ras_flush_o         = 1'b0;
`endif

   always_comb begin
      w_src     = pred_source(f_icode_i, w_ras_hit);
      w_next_pc = f_valP_i;
      case (w_src)
         SRC_VALC: w_next_pc = f_valC_i;
         SRC_RAS:  w_next_pc = w_ras_top;
         default:  w_next_pc = f_valP_i;
      endcase
   end

   // A mispredict never touches the prediction; PC selection does the correction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pred_pc <= '0;
      end else if (!F_stall_i) begin
         r_pred_pc <= w_next_pc;
      end
   end

   assign F_predPC_o = r_pred_pc;

endmodule

`default_nettype wire

// File: tb/tb_predict_pc.sv
// Directed self-checking bench for predict_pc; expectations follow the RAS_EN build.
`default_nettype none

module tb_predict_pc;
   import predict_pc_pkg::*;

`ifdef RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  f_icode_i = INOP;
   logic [31:0] f_valC_i = '0;
   logic [31:0] f_valP_i = '0;
   logic        F_stall_i = 1'b0;
   logic [7:0]  M_icode_i = INOP;
   logic        M_Cnd_i = 1'b0;
   logic [31:0] F_predPC_o;
   logic [4:0]  ras_count_o;
   logic        ras_flush_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   predict_pc #(.RAS_DEPTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .f_icode_i   (f_icode_i),
      .f_valC_i    (f_valC_i),
      .f_valP_i    (f_valP_i),
      .F_stall_i   (F_stall_i),
      .M_icode_i   (M_icode_i),
      .M_Cnd_i     (M_Cnd_i),
      .F_predPC_o  (F_predPC_o),
      .ras_count_o (ras_count_o),
      .ras_flush_o (ras_flush_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [7:0] ic, input logic [31:0] vc, input logic [31:0] vp);
      f_icode_i = ic;
      f_valC_i  = vc;
      f_valP_i  = vp;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_checks++;
      if (F_predPC_o !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %h want 0", F_predPC_o); end
      n_checks++;
      if (ras_count_o !== 5'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", ras_count_o); end
      n_checks++;
      if (ras_flush_o !== 1'b0) begin n_errors++; $display("FAIL reset_flush got %b want 0", ras_flush_o); end
   endtask

   task automatic test_basic();
      rst = 1'b1;
      fetch(IRRMOVL, 32'h0, 32'h2);
      tick();
      n_checks++;
      if (F_predPC_o !== 32'h2) begin n_errors++; $display("FAIL basic_pc got %h want 2", F_predPC_o); end
   endtask

   task automatic test_call_ret();
      fetch(ICALL, 32'h100, 32'h25);
      tick();
      n_checks++;
      if (F_predPC_o !== 32'h100) begin n_errors++; $display("FAIL call_pc got %h want 100", F_predPC_o); end
      n_checks++;
      if (ras_count_o !== (RAS ? 5'd1 : 5'd0)) begin n_errors++; $display("FAIL call_count got %0d want %0d", ras_count_o, RAS ? 1 : 0); end
      fetch(IRET, 32'h0, 32'h105);
      tick();
      n_checks++;
      if (F_predPC_o !== (RAS ? 32'h25 : 32'h105)) begin n_errors++; $display("FAIL ret_pc got %h want %h", F_predPC_o, RAS ? 32'h25 : 32'h105); end
      n_checks++;
      if (ras_count_o !== 5'd0) begin n_errors++; $display("FAIL ret_count got %0d want 0", ras_count_o); end
   endtask

   task automatic test_jump();
      fetch(IJXX, 32'h300, 32'h50);
      tick();
      n_checks++;
      if (F_predPC_o !== 32'h300) begin n_errors++; $display("FAIL jump_pc got %h want 300", F_predPC_o); end
   endtask

   task automatic test_overflow();
      logic [4:0]  exp_cnt;
      logic [31:0] exp_pc;
      for (int i = 0; i < 9; i++) begin
         fetch(ICALL, 32'h1000 + 32'(i), 32'h10 + 32'(i));
         tick();
         exp_cnt = RAS ? ((i + 1 > 8) ? 5'd8 : 5'(i + 1)) : 5'd0;
         n_checks++;
         if (ras_count_o !== exp_cnt) begin n_errors++; $display("FAIL ovf_push_count[%0d] got %0d want %0d", i, ras_count_o, exp_cnt); end
      end
      for (int i = 0; i < 8; i++) begin
         fetch(IRET, 32'h0, 32'h2000 + 32'(i));
         tick();
         exp_pc  = RAS ? (32'h18 - 32'(i)) : (32'h2000 + 32'(i));
         exp_cnt = RAS ? 5'(7 - i) : 5'd0;
         n_checks++;
         if (F_predPC_o !== exp_pc) begin n_errors++; $display("FAIL ovf_pop_pc[%0d] got %h want %h", i, F_predPC_o, exp_pc); end
         n_checks++;
         if (ras_count_o !== exp_cnt) begin n_errors++; $display("FAIL ovf_pop_count[%0d] got %0d want %0d", i, ras_count_o, exp_cnt); end
      end
      fetch(IRET, 32'h0, 32'h3000);
      tick();
      n_checks++;
      if (F_predPC_o !== 32'h3000) begin n_errors++; $display("FAIL empty_pop_pc got %h want 3000", F_predPC_o); end
      n_checks++;
      if (ras_count_o !== 5'd0) begin n_errors++; $display("FAIL empty_pop_count got %0d want 0", ras_count_o); end
   endtask

   task automatic test_mispredict();
      fetch(ICALL, 32'h500, 32'h40);
      tick();
      fetch(INOP, 32'h0, 32'h42);
      M_icode_i = IJXX;
      M_Cnd_i   = 1'b1;
      tick();
      n_checks++;
      if (ras_count_o !== (RAS ? 5'd1 : 5'd0)) begin n_errors++; $display("FAIL taken_count got %0d want %0d", ras_count_o, RAS ? 1 : 0); end
      M_Cnd_i = 1'b0;
      fetch(ICALL, 32'h600, 32'h44);
      tick();
      n_checks++;
      if (F_predPC_o !== 32'h600) begin n_errors++; $display("FAIL misp_pc got %h want 600", F_predPC_o); end
      n_checks++;
      if (ras_count_o !== 5'd0) begin n_errors++; $display("FAIL misp_count got %0d want 0", ras_count_o); end
      n_checks++;
      if (ras_flush_o !== RAS) begin n_errors++; $display("FAIL misp_flush got %b want %b", ras_flush_o, RAS); end
      M_icode_i = INOP;
      fetch(IRET, 32'h0, 32'h4C);
      tick();
      n_checks++;
      if (ras_flush_o !== 1'b0) begin n_errors++; $display("FAIL misp_flush_end got %b want 0", ras_flush_o); end
      n_checks++;
      if (F_predPC_o !== 32'h4C) begin n_errors++; $display("FAIL misp_ret_pc got %h want 4c", F_predPC_o); end
   endtask

   task automatic test_stall();
      fetch(INOP, 32'h0, 32'h70);
      tick();
      F_stall_i = 1'b1;
      fetch(ICALL, 32'h200, 32'h74);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (F_predPC_o !== 32'h70) begin n_errors++; $display("FAIL stall_pc[%0d] got %h want 70", i, F_predPC_o); end
         n_checks++;
         if (ras_count_o !== 5'd0) begin n_errors++; $display("FAIL stall_count[%0d] got %0d want 0", i, ras_count_o); end
      end
      F_stall_i = 1'b0;
      tick();
      n_checks++;
      if (F_predPC_o !== 32'h200) begin n_errors++; $display("FAIL release_pc got %h want 200", F_predPC_o); end
      fetch(INOP, 32'h0, 32'h204);
      tick();
      n_checks++;
      if (ras_count_o !== (RAS ? 5'd1 : 5'd0)) begin n_errors++; $display("FAIL release_count got %0d want %0d", ras_count_o, RAS ? 1 : 0); end
      fetch(IRET, 32'h0, 32'h300);
      tick();
      n_checks++;
      if (F_predPC_o !== (RAS ? 32'h74 : 32'h300)) begin n_errors++; $display("FAIL release_ret_pc got %h want %h", F_predPC_o, RAS ? 32'h74 : 32'h300); end
   endtask

   task automatic test_async_reset();
      fetch(ICALL, 32'h80, 32'h90);
      tick();
      fetch(ICALL, 32'h84, 32'h94);
      tick();
      fetch(ICALL, 32'h88, 32'h98);
      tick();
      n_checks++;
      if (F_predPC_o !== 32'h88) begin n_errors++; $display("FAIL pre_rst_pc got %h want 88", F_predPC_o); end
      n_checks++;
      if (ras_count_o !== (RAS ? 5'd3 : 5'd0)) begin n_errors++; $display("FAIL pre_rst_count got %0d want %0d", ras_count_o, RAS ? 3 : 0); end
      fetch(ICALL, 32'h8C, 32'h9C);
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (F_predPC_o !== 32'h0) begin n_errors++; $display("FAIL async_rst_pc got %h want 0", F_predPC_o); end
      n_checks++;
      if (ras_count_o !== 5'd0) begin n_errors++; $display("FAIL async_rst_count got %0d want 0", ras_count_o); end
      tick();
      n_checks++;
      if (ras_count_o !== 5'd0) begin n_errors++; $display("FAIL rst_hold_count got %0d want 0", ras_count_o); end
      rst = 1'b1;
      fetch(IRET, 32'h0, 32'h99);
      tick();
      n_checks++;
      if (F_predPC_o !== 32'h99) begin n_errors++; $display("FAIL post_rst_pc got %h want 99", F_predPC_o); end
      n_checks++;
      if (ras_flush_o !== 1'b0) begin n_errors++; $display("FAIL post_rst_flush got %b want 0", ras_flush_o); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_call_ret();
      test_jump();
      test_overflow();
      test_mispredict();
      test_stall();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/predict_pc.md
PREDICT_PC -- requirements
Module: predict_pc

Interface
REQ-001 The module SHALL have parameter RAS_DEPTH, default 8, the return-address-stack entry count (power of two, 2..16).
REQ-002 The module SHALL have port clk, in, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, in, 1, the reset: asynchronous, active-low.
REQ-004 The module SHALL have port f_icode_i, in, `BYTE, the icode of the instruction in fetch.
REQ-005 The module SHALL have port f_valC_i, in, `WORD, the fetched constant word.
REQ-006 The module SHALL have port f_valP_i, in, `WORD, the fall-through address.
REQ-007 The module SHALL have port F_stall_i, in, 1, the F-register hold request.
REQ-008 The module SHALL have port M_icode_i, in, `BYTE, the icode in the memory stage.
REQ-009 The module SHALL have port M_Cnd_i, in, 1, the branch condition in the memory stage.
REQ-010 The module SHALL have port F_predPC_o, out, `WORD, the registered predicted PC feeding PC selection.
REQ-011 The module SHALL have port ras_count_o, out, 5, the current number of valid RAS entries.
REQ-012 The module SHALL have port ras_flush_o, out, 1, a one-cycle pulse when the RAS is cleared by mispredict.

Function
REQ-013 Next-prediction selection SHALL be combinational: IJXX or ICALL -> f_valC_i; IRET with a non-empty RAS -> RAS top; every other case -> f_valP_i.
REQ-014 F_predPC_o SHALL load the selected value on each clock edge with F_stall_i=0, and SHALL hold when F_stall_i=1; the latency from fetch inputs to F_predPC_o is one cycle.
REQ-015 On an unstalled cycle, ICALL SHALL push f_valP_i, and IRET SHALL pop the top entry.
REQ-016 With F_stall_i=1 there SHALL be no push and no pop.
REQ-017 A push when full (count=RAS_DEPTH) SHALL overwrite the oldest entry; the count SHALL stay at RAS_DEPTH and the write pointer SHALL wrap modulo RAS_DEPTH.
REQ-018 A pop when empty SHALL leave the count at 0, and prediction SHALL fall back to f_valP_i.
REQ-019 A mispredict is M_icode_i==IJXX and !M_Cnd_i; on it, the RAS SHALL be cleared (count=0) on that edge, and ras_flush_o SHALL be 1 in the following cycle.
REQ-020 When a mispredict and a fetch push/pop fall on the same edge, the flush SHALL take priority and the push/pop SHALL be discarded.
REQ-021 A mispredict SHALL NOT alter F_predPC_o; PC correction remains the job of PC selection.
REQ-022 All address arithmetic SHALL be `WORD wide; there is no address computation beyond selection.

Reset
REQ-023 On rst=0, asynchronously: F_predPC_o=0, ras_count_o=0, ras_flush_o=0, and the RAS pointers SHALL be 0.
REQ-024 RAS entry contents need not be cleared.
REQ-025 Reset asserted mid-operation SHALL discard any pending push/pop.
REQ-026 The first clock edge after rst deasserts SHALL behave as a normal cycle.

Configuration
REQ-027 The macro RAS_EN SHALL control the return-address stack.
REQ-028 With RAS_EN defined, the RAS SHALL be built and REQ-013..REQ-020 apply in full.
REQ-029 With RAS_EN undefined, no stack storage SHALL be built: IRET predicts f_valP_i, ras_count_o is tied 0, and ras_flush_o is tied 0.

Structure
REQ-030 IJXX, ICALL, IRET, `WORD and `BYTE SHALL come from defines.v.
REQ-031 The RAS_DEPTH default SHALL be defined in defines.v.
REQ-032 The stack SHALL be a sub-module ras_stack (ports: push, pop, flush, data in, top out, count out), instantiated only under RAS_EN.

Verification
REQ-033 Scenario 1: release reset, then fetch IRRMOVL with valP=0x0002 -> F_predPC_o=0x0002 after one edge.
REQ-034 Scenario 2: fetch ICALL valC=0x0100 valP=0x0025, later IRET with valP=0x0105 -> predictions 0x0100 then 0x0025, ras_count_o 1 then 0.
REQ-035 Scenario 3: nine ICALLs with valP=0x10..0x18 (RAS_DEPTH=8), then eight IRETs -> count saturates at 8; pops return 0x18 down to 0x11; a ninth IRET predicts its own valP.
REQ-036 Scenario 4: push 0x40, then M_icode_i=IJXX, M_Cnd_i=0 in the same cycle as an ICALL fetch -> count=0 and ras_flush_o pulses one cycle.
REQ-037 Scenario 5: F_stall_i=1 for 3 cycles during an ICALL with valC=0x0200 -> F_predPC_o and count unchanged; one push occurs after release.
REQ-038 Scenario 6: assert rst mid-stream with count=3, F_predPC_o=0x0088 -> outputs reach 0 immediately, before the next clock edge.
